mem_split_engine: RTL
=====================

Name: mem_split_engine

Overview:
- Parametrised bus-access splitter between a data-cache/datapath requester and the shared memory interconnect.
- Takes one read or write of 1..DATA_W/8 bytes at any byte address and issues the minimum number of BUS_W-aligned bus beats with byte enables, holding bus ownership for the whole access.
- For reads, it accumulates the returned beats, realigns them and returns a right-justified result through a valid/ready handshake.
- Successor to the fixed 64/32-bit dcache write-count path: width-generic, adds a read path, and uses byte enables instead of a 2-bit size code.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 64, maximum request width in bits; power of two, at least BUS_W.
- BUS_W, 32, interconnect data width in bits; power of two, at least 8.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid and req_ready are both high.
- req_rd_wr  in  1  1 = read, 0 = write.
- req_addr  in  ADDR_W  byte address, any alignment.
- req_size  in  clog2(DATA_W/8)  byte count minus 1.
- req_data  in  DATA_W  write data, right-justified.
- rsp_valid  out  1  read result valid.
- rsp_ready  in  1  read result consumed.
- rsp_data  out  DATA_W  read data, right-justified; bytes above the size are zero.
- mem_req  out  1  beat request.
- mem_rd_wr  out  1  beat direction.
- mem_addr  out  ADDR_W  beat address, BUS_W/8-aligned.
- mem_be  out  BUS_W/8  byte enables.
- mem_wdata  out  BUS_W  write data.
- mem_rdata  in  BUS_W  read data.
- mem_data_valid  in  1  beat complete; read data is valid in the same cycle.
- grant_in  in  1  daisy-chain grant.
- grant_out  out  1  grant passed downstream.
- bus_busy_in  in  1  bus held by another master.
- bus_busy_out  out  1  this block owns the bus.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - req_ready=1; rsp_valid=0; mem_req=0; bus_busy_out=0; mem_be=0.
  - grant_out follows grant_in.
  - Internal beat counter and data registers are cleared.
  - Reset mid-transaction abandons the access: no further beats, bus released in the next cycle.
- Decode at accept:
  - off = req_addr[clog2(BUS_W/8)-1:0].
  - nbeats = ceil((off + req_size + 1) / (BUS_W/8)), range 1..DATA_W/BUS_W+1.
  - base = req_addr with the low offset bits cleared.
  - Latch all request fields.
- States:
  - IDLE: req_ready=1. On handshake go to ARB (no same-cycle bus activity).
  - ARB: req_ready=0; grant_out=0. When grant_in=1 and bus_busy_in=0, set bus_busy_out=1 and go to BEAT with beat=0.
  - BEAT: mem_req=1; mem_addr = base + beat*(BUS_W/8). mem_be = the slice of the request byte mask shifted left by off. mem_wdata = the matching slice of req_data shifted left by off*8, with zero fill. On mem_data_valid:
    - read: store mem_rdata into accumulator slice `beat`.
    - if beat==nbeats-1: drop bus_busy_out and mem_req in the next cycle; go to RESP for reads, IDLE for writes.
    - else beat+1.
    - mem_data_valid outside BEAT is ignored.
  - RESP: rsp_valid=1; rsp_data = accumulator shifted right by off*8, masked to req_size+1 bytes. Held stable until rsp_ready, then go to IDLE.
- Handshake rules:
  - One outstanding request.
  - req_ready=0 in ARB, BEAT and RESP.
  - A new request can be accepted in the cycle after rsp handshake or after the last write beat.
- Latency: an aligned single-beat access with immediate grant and 1-cycle memory takes 3 cycles from accept to bus release.
- Arbitration:
  - In IDLE/RESP: grant_out = grant_in.
  - In ARB/BEAT: grant_out=0.
  - bus_busy_out is continuous from grant to last beat; no release between beats.
- Address arithmetic wraps modulo 2^ADDR_W.

Decomposition:
- Package mem_split_pkg holds:
  - localparams BUS_B=BUS_W/8, DATA_B=DATA_W/8, OFF_W, MAX_BEATS, BEAT_W.
  - state encoding IDLE/ARB/BEAT/RESP.
- Sub-module mem_split_align: combinational byte shifter producing the shifted write window and byte mask, and the read realign/mask. Shared by the write and read paths.

Test Plan:
- Write, req_addr=0x1003, size=7, data=0x8877665544332211 -> three beats:
  - 0x1000 be=1000 wdata=0x11000000
  - 0x1004 be=1111 wdata=0x55443322
  - 0x1008 be=0111 wdata=0x00887766
  - then req_ready=1.
- Write, 0x2000, size=3, data=0xDEADBEEF, grant immediate -> one beat: 0x2000 be=1111 wdata=0xDEADBEEF; bus_busy_out high exactly one beat.
- Read, 0x3003, size=1; memory returns 0xAABBCCDD then 0x11223344 -> beats at 0x3000 (be=1000) and 0x3004 (be=0001); rsp_data=0x44AA; rsp held 3 cycles with rsp_ready=0.
- Arbitration:
  - Idle with grant_in=1 -> grant_out=1.
  - Request with bus_busy_in=1 for 5 cycles -> stays in ARB, mem_req=0, grant_out=0; first beat issues the cycle after bus_busy_in falls.
- Reset low during beat 2 of the 0x1003 write -> next cycle mem_req=0, bus_busy_out=0, req_ready=1; the following request completes normally.

Source files
------------

// File: rtl/mem_split_pkg.sv
// Shared types and sizing helpers for the memory access splitter.
// The constants describe the default 64-bit request / 32-bit bus configuration.
package mem_split_pkg;

    localparam int BUS_W_DEF  = 32;
    localparam int DATA_W_DEF = 64;

    localparam int BUS_B     = BUS_W_DEF / 8;
    localparam int DATA_B    = DATA_W_DEF / 8;
    localparam int OFF_W     = $clog2(BUS_B);
    localparam int MAX_BEATS = DATA_B / BUS_B + 1;
    localparam int BEAT_W    = $clog2(MAX_BEATS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        BEAT = 2'd2,
        RESP = 2'd3
    } state_t;

    // An unaligned access can straddle one extra bus word.
    function automatic int beats_max(input int data_w, input int bus_w);
        return data_w / bus_w + 1;
    endfunction

endpackage

// File: rtl/mem_split_align.sv
// Byte shifter shared by both paths: builds the per-beat write window and byte
// enables, and realigns/masks the accumulated read words to a right-justified result.
module mem_split_align
    import mem_split_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int BUS_W  = 32
) (
    input  logic [$clog2(BUS_W/8)-1:0]                  off,
    input  logic [$clog2(DATA_W/8)-1:0]                 size,
    input  logic [$clog2(beats_max(DATA_W, BUS_W))-1:0] beat,
    input  logic [DATA_W-1:0]                           wdata,
    input  logic [beats_max(DATA_W, BUS_W)*BUS_W-1:0]   acc,
    output logic [BUS_W-1:0]                            beat_wdata,
    output logic [BUS_W/8-1:0]                          beat_be,
    output logic [DATA_W-1:0]                           rdata
);

    localparam int DATA_BYTES = DATA_W / 8;
    localparam int BUS_BYTES  = BUS_W / 8;
    localparam int WIN_BYTES  = beats_max(DATA_W, BUS_W) * BUS_BYTES;
    localparam int WIN_W      = WIN_BYTES * 8;

    logic [DATA_BYTES-1:0] byte_mask;
    logic [DATA_W-1:0]     bit_mask;
    logic [WIN_BYTES-1:0]  win_be;
    logic [WIN_W-1:0]      win_data;
    logic [WIN_W-1:0]      acc_shift;

    always_comb begin
        byte_mask = '0;
        bit_mask  = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (i <= int'(size)) begin
                byte_mask[i]       = 1'b1;
                bit_mask[i*8 +: 8] = 8'hff;
            end
        end
        // Disabled lanes carry zeros so the bus never sees stale request bytes.
        win_be     = {{(WIN_BYTES - DATA_BYTES){1'b0}}, byte_mask} << off;
        win_data   = {{(WIN_W - DATA_W){1'b0}}, wdata & bit_mask} << {off, 3'b000};
        beat_wdata = win_data[int'(beat)*BUS_W +: BUS_W];
        beat_be    = win_be[int'(beat)*BUS_BYTES +: BUS_BYTES];
        acc_shift  = acc >> {off, 3'b000};
        rdata      = acc_shift[DATA_W-1:0] & bit_mask;
    end

endmodule

// File: rtl/mem_split_engine.sv
// Splits one unaligned read/write of up to DATA_W bits into aligned BUS_W beats,
// owning the shared bus for the whole access and returning realigned read data.
module mem_split_engine
    import mem_split_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int BUS_W  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_rd_wr,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [$clog2(DATA_W/8)-1:0]  req_size,
    input  logic [DATA_W-1:0]            req_data,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_W-1:0]            rsp_data,
    output logic                         mem_req,
    output logic                         mem_rd_wr,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [BUS_W/8-1:0]           mem_be,
    output logic [BUS_W-1:0]             mem_wdata,
    input  logic [BUS_W-1:0]             mem_rdata,
    input  logic                         mem_data_valid,
    input  logic                         grant_in,
    output logic                         grant_out,
    input  logic                         bus_busy_in,
    output logic                         bus_busy_out,
    output state_t                       dbg_state
);

    // Handshake: a transfer happens on a clk edge where valid and ready are both
    // high; ready never depends on valid, and valid holds its payload until taken.
    localparam int OFF_BITS  = $clog2(BUS_W / 8);
    localparam int SIZE_BITS = $clog2(DATA_W / 8);
    localparam int BEAT_BITS = $clog2(beats_max(DATA_W, BUS_W));
    localparam int WIN_W     = beats_max(DATA_W, BUS_W) * BUS_W;

    state_t                state;
    logic [BEAT_BITS-1:0]  beat;
    logic [BEAT_BITS-1:0]  last_beat;
    logic [OFF_BITS-1:0]   off_q;
    logic [SIZE_BITS-1:0]  size_q;
    logic [ADDR_W-1:0]     base_q;
    logic                  rd_wr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [WIN_W-1:0]      acc;

    logic [OFF_BITS-1:0]   req_off;
    logic [SIZE_BITS:0]    span;
    logic [BEAT_BITS-1:0]  req_last;
    logic [BUS_W-1:0]      beat_wdata;
    logic [BUS_W/8-1:0]    beat_be;
    logic [DATA_W-1:0]     aligned_rdata;

    // Last beat index = floor((off + size) / bus bytes), i.e. nbeats - 1.
    always_comb begin
        req_off  = req_addr[OFF_BITS-1:0];
        span     = {{(SIZE_BITS + 1 - OFF_BITS){1'b0}}, req_off} + {1'b0, req_size};
        req_last = BEAT_BITS'(span >> OFF_BITS);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            beat         <= '0;
            last_beat    <= '0;
            off_q        <= '0;
            size_q       <= '0;
            base_q       <= '0;
            rd_wr_q      <= 1'b0;
            wdata_q      <= '0;
            acc          <= '0;
            bus_busy_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        off_q     <= req_off;
                        size_q    <= req_size;
                        base_q    <= {req_addr[ADDR_W-1:OFF_BITS], {OFF_BITS{1'b0}}};
                        rd_wr_q   <= req_rd_wr;
                        wdata_q   <= req_data;
                        last_beat <= req_last;
                        acc       <= '0;
                        state     <= ARB;
                    end
                end
                ARB: begin
                    if (grant_in && !bus_busy_in) begin
                        bus_busy_out <= 1'b1;
                        beat         <= '0;
                        state        <= BEAT;
                    end
                end
                BEAT: begin
                    if (mem_data_valid) begin
                        if (rd_wr_q) begin
                            acc[int'(beat)*BUS_W +: BUS_W] <= mem_rdata;
                        end
                        if (beat == last_beat) begin
                            bus_busy_out <= 1'b0;
                            state        <= rd_wr_q ? RESP : IDLE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    mem_split_align #(
        .DATA_W (DATA_W),
        .BUS_W  (BUS_W)
    ) u_align (
        .off        (off_q),
        .size       (size_q),
        .beat       (beat),
        .wdata      (wdata_q),
        .acc        (acc),
        .beat_wdata (beat_wdata),
        .beat_be    (beat_be),
        .rdata      (aligned_rdata)
    );

    // Bus-facing outputs are decoded from registered state only.
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        mem_req   = (state == BEAT);
        mem_rd_wr = (state == BEAT) && rd_wr_q;
        mem_addr  = (state == BEAT) ? base_q + (ADDR_W'(beat) << OFF_BITS) : '0;
        mem_be    = (state == BEAT) ? beat_be : '0;
        mem_wdata = (state == BEAT && !rd_wr_q) ? beat_wdata : '0;
        rsp_data  = (state == RESP) ? aligned_rdata : '0;
        grant_out = (state == IDLE || state == RESP) && grant_in;
        dbg_state = state;
    end

endmodule
